// File: rtl/arrow_pkg.sv
// Shared slot type, scheduler state encoding and 720p timing constants
// for the arrow lane scheduler.
package arrow_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int V_TOTAL  = 750;

  typedef struct packed {
    logic       valid;
    logic [9:0] y;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    HIT
  } sched_state_t;

endpackage

// File: rtl/arrow_min_finder.sv
// Combinational search for the valid slot with the smallest y; ties resolve
// to the lowest slot index because only a strictly smaller y replaces the pick.
module arrow_min_finder
  import arrow_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  slot_t            slots_i [NUM_SLOTS],
  output logic [IDX_W-1:0] minIdx_o,
  output logic             found_o
);

  logic [9:0] minY;

  always_comb begin
    minIdx_o = '0;
    found_o  = 1'b0;
    minY     = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slots_i[i].valid && (!found_o || (slots_i[i].y < minY))) begin
        found_o  = 1'b1;
        minIdx_o = IDX_W'(i);
        minY     = slots_i[i].y;
      end
    end
  end

endmodule

// File: rtl/arrow_lane_scheduler.sv
// One lane of scrolling arrows: spawn handshake, per-frame scroll during
// vblank, hit/miss retirement and per-scanline selection of the shared sprite.
module arrow_lane_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int LANE_X     = 200,
  parameter int SPRITE_H   = 100,
  parameter int SPAWN_Y    = 720,
  parameter int SPEED      = 4,
  parameter int HIT_WINDOW = 120,
  parameter int H_ACTIVE   = arrow_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = arrow_pkg::V_ACTIVE,
  parameter int PARK_Y     = 1023,
  parameter int IDX_W      = $clog2(NUM_SLOTS),
  parameter int CNT_W      = $clog2(NUM_SLOTS) + 1
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             spawn_valid_in,
  output logic             spawn_ready_out,
  input  logic             hit_in,
  output logic [10:0]      x_out,
  output logic [9:0]       y_out,
  output logic             hit_ok_out,
  output logic             hit_bad_out,
  output logic             miss_out,
  output logic [CNT_W-1:0] active_count_out
);

  import arrow_pkg::slot_t;
  import arrow_pkg::sched_state_t;
  import arrow_pkg::IDLE;
  import arrow_pkg::UPDATE;
  import arrow_pkg::HIT;
  import arrow_pkg::V_TOTAL;

  localparam logic [9:0]       SPEED_Y   = 10'(SPEED);
  localparam logic [9:0]       SPAWN_Y10 = 10'(SPAWN_Y);
  localparam logic [9:0]       SPACING_Y = 10'(SPAWN_Y - SPRITE_H);
  localparam logic [9:0]       WINDOW_Y  = 10'(HIT_WINDOW);
  localparam logic [9:0]       PARK_Y10  = 10'(PARK_Y);
  localparam logic [9:0]       VTRIG10   = 10'(V_ACTIVE);
  localparam logic [9:0]       VLAST10   = 10'(V_TOTAL - 1);
  localparam logic [10:0]      HSEL11    = 11'(H_ACTIVE);
  localparam logic [10:0]      HEIGHT11  = 11'(SPRITE_H);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SLOTS - 1);

  slot_t              slots_q [NUM_SLOTS];
  slot_t              slots_d [NUM_SLOTS];
  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pending_q, pending_d;
  logic [9:0]         yOut_q, yOut_d;
  logic               spawnReady_q, spawnReady_d;
  logic               hitOk_q, hitOk_d;
  logic               hitBad_q, hitBad_d;
  logic               miss_q, miss_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               frameTrig;
  logic               spawnAccept;
  logic               freeFound;
  logic [IDX_W-1:0]   freeIdx;
  logic               freeNext;
  logic               spacingOk;
  logic [IDX_W-1:0]   minIdx;
  logic               minFound;
  logic [10:0]        nextLine;
  logic               selFound;
  logic [9:0]         selY;

  assign frameTrig   = (hcount_in == 11'd0) && (vcount_in == VTRIG10);
  assign spawnAccept = spawn_valid_in && spawnReady_q;

  arrow_min_finder #(
    .NUM_SLOTS(NUM_SLOTS),
    .IDX_W    (IDX_W)
  ) minFinder (
    .slots_i (slots_q),
    .minIdx_o(minIdx),
    .found_o (minFound)
  );

  // Slot bookkeeping and FSM next state. Spawn is only accepted while ready,
  // which is never asserted outside IDLE, so it cannot collide with UPDATE/HIT.
  always_comb begin
    slots_d   = slots_q;
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q | hit_in;
    hitOk_d   = 1'b0;
    hitBad_d  = 1'b0;
    miss_d    = 1'b0;
    freeFound = 1'b0;
    freeIdx   = '0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slots_q[i].valid && !freeFound) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end

    if (spawnAccept && freeFound) begin
      slots_d[freeIdx].valid = 1'b1;
      slots_d[freeIdx].y     = SPAWN_Y10;
    end

    case (state_q)
      IDLE: begin
        if (frameTrig) begin
          state_d = UPDATE;
          idx_d   = '0;
        end else if (pending_q) begin
          state_d = HIT;
        end
      end
      UPDATE: begin
        if (slots_q[idx_q].valid) begin
          if (slots_q[idx_q].y < SPEED_Y) begin
            slots_d[idx_q].valid = 1'b0;
            miss_d               = 1'b1;
          end else begin
            slots_d[idx_q].y = slots_q[idx_q].y - SPEED_Y;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      HIT: begin
        if (minFound && (slots_q[minIdx].y < WINDOW_Y)) begin
          slots_d[minIdx].valid = 1'b0;
          hitOk_d               = 1'b1;
        end else begin
          hitBad_d = 1'b1;
        end
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready and count look at next-cycle slots so they never lag an accept.
    freeNext  = 1'b0;
    spacingOk = 1'b1;
    count_d   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slots_d[i].valid) freeNext = 1'b1;
      if (slots_d[i].valid && (slots_d[i].y > SPACING_Y)) spacingOk = 1'b0;
      count_d = count_d + CNT_W'(slots_d[i].valid);
    end
    spawnReady_d = (state_d == IDLE) && freeNext && spacingOk;
  end

  // Per-line pick of the arrow covering the next line, widened to 11 bits.
  always_comb begin
    nextLine = (vcount_in == VLAST10) ? 11'd0 : ({1'b0, vcount_in} + 11'd1);
    selFound = 1'b0;
    selY     = PARK_Y10;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!selFound && slots_q[i].valid &&
          ({1'b0, slots_q[i].y} <= nextLine) &&
          (nextLine < ({1'b0, slots_q[i].y} + HEIGHT11))) begin
        selFound = 1'b1;
        selY     = slots_q[i].y;
      end
    end
    yOut_d = (hcount_in == HSEL11) ? selY : yOut_q;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '{valid: 1'b0, y: 10'd0};
      end
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      yOut_q       <= PARK_Y10;
      spawnReady_q <= 1'b0;
      hitOk_q      <= 1'b0;
      hitBad_q     <= 1'b0;
      miss_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      slots_q      <= slots_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      yOut_q       <= yOut_d;
      spawnReady_q <= spawnReady_d;
      hitOk_q      <= hitOk_d;
      hitBad_q     <= hitBad_d;
      miss_q       <= miss_d;
      count_q      <= count_d;
    end
  end

  assign x_out            = 11'(LANE_X);
  assign y_out            = yOut_q;
  assign spawn_ready_out  = spawnReady_q;
  assign hit_ok_out       = hitOk_q;
  assign hit_bad_out      = hitBad_q;
  assign miss_out         = miss_q;
  assign active_count_out = count_q;

endmodule

// File: doc/arrow_lane_scheduler.md
Name: arrow_lane_scheduler

Overview:
- Controls one lane of scrolling arrow sprites. It holds up to NUM_SLOTS arrows, accepts spawn requests through a valid/ready handshake, and moves every arrow upward once per frame during vertical blank.
- It retires arrows that are hit or that leave the top of the screen.
- Once per scanline it picks which arrow drives the lane's single up_arrow_sprite instance through x_out/y_out. This lets one shared image/palette ROM pair serve several on-screen arrows.

Parameters:
- NUM_SLOTS, 4, maximum simultaneous arrows in the lane (power of 2, 2..8).
- LANE_X, 200, fixed sprite x position driven on x_out.
- SPRITE_H, 100, sprite height in lines; also the minimum vertical spacing between arrows.
- SPAWN_Y, 720, y given to a newly spawned arrow (just below the visible area).
- SPEED, 4, lines moved upward per frame.
- HIT_WINDOW, 120, an arrow with y < HIT_WINDOW is hittable.
- H_ACTIVE, 1280, first hblank hcount; the per-line selection point.
- V_ACTIVE, 720, first vblank vcount; the frame-update trigger line.
- PARK_Y, 1023, y_out value when no arrow is selected (sprite is guaranteed off-screen).

Ports:
- pixel_clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-high reset
- hcount_in  input  11  current horizontal pixel count
- vcount_in  input  10  current vertical line count
- spawn_valid_in  input  1  request to spawn an arrow
- spawn_ready_out  output  1  spawn accepted on a cycle where valid && ready
- hit_in  input  1  single-cycle player press for this lane
- x_out  output  11  sprite x; constant LANE_X
- y_out  output  10  selected arrow y, or PARK_Y
- hit_ok_out  output  1  1-cycle pulse: press retired an arrow
- hit_bad_out  output  1  1-cycle pulse: press found nothing hittable
- miss_out  output  1  1-cycle pulse: an arrow scrolled off the top
- active_count_out  output  $clog2(NUM_SLOTS)+1  number of valid slots

Behaviour:
- Slot state per slot: valid bit plus 10-bit y. Reset clears all valid bits and sets y to 0.
- Output reset values: y_out=PARK_Y, spawn_ready_out=0, all pulses 0, active_count_out=0. x_out is always LANE_X.
- FSM states: IDLE, UPDATE, HIT. Reset state is IDLE.
- IDLE -> UPDATE on the cycle where hcount_in==0 && vcount_in==V_ACTIVE. A counter idx starts at 0.
- UPDATE handles one slot per cycle, idx = 0..NUM_SLOTS-1:
  - valid slot with y < SPEED: clear valid and pulse miss_out.
  - otherwise valid slot: y -= SPEED.
  - After the last idx, return to IDLE. UPDATE takes exactly NUM_SLOTS cycles.
- Pending hit:
  - hit_in sets a pending flag in any state.
  - A second hit_in while the flag is already pending is dropped.
  - In IDLE, a pending flag moves the FSM to HIT, unless the frame trigger fires that same cycle; the trigger has priority.
- HIT lasts 1 cycle:
  - Target is the valid slot with the smallest y; ties go to the lowest index.
  - If the target's y < HIT_WINDOW: clear it and pulse hit_ok_out.
  - Otherwise, or if no slot is valid: pulse hit_bad_out.
  - Clear the pending flag and return to IDLE.
- Spawn:
  - spawn_ready_out = state==IDLE && a free slot exists && no valid slot has y > SPAWN_Y - SPRITE_H.
  - It is a registered combinational function of current state, so it may change every cycle.
  - On accept, write the lowest-index free slot with valid=1, y=SPAWN_Y. The new arrow appears in active_count_out on the next cycle.
  - Spawn is not possible during UPDATE/HIT. A spawn request in the same cycle as the frame trigger is accepted, and the FSM enters UPDATE on that same cycle.
- Line selection, evaluated when hcount_in==H_ACTIVE:
  - next line L = (vcount_in==749) ? 0 : vcount_in+1.
  - Pick the lowest-index valid slot with y <= L < y+SPRITE_H, comparing at 11 bits so nothing overflows.
  - Register its y into y_out; if no slot matches, y_out=PARK_Y.
  - y_out is held for the rest of the line, so it is stable through the active pixels of L.
  - Selection reads the slot registers as they are on that cycle. UPDATE only runs at vblank, so it never races an active line.
- Spacing guarantees at most one arrow matches per line. Lowest index wins if that is ever violated.
- active_count_out = popcount of valid bits, registered.
- Reset asserted mid-UPDATE or mid-HIT returns to IDLE immediately with all slots cleared and the pending flag cleared.

Decomposition:
- Shared package arrow_pkg:
  - typedef slot_t {logic valid; logic [9:0] y;}
  - enum sched_state_t {IDLE, UPDATE, HIT}
  - 720p timing constants H_ACTIVE=1280, V_ACTIVE=720, V_TOTAL=750.
- One sub-module, arrow_min_finder: combinational smallest-y valid slot, outputting index and found flag. It is used by HIT.

Test Plan:
- Reset then idle one frame -> y_out=1023, active_count_out=0, spawn_ready_out=1, no pulses.
- Spawn once -> slot0 y=720; after 3 frame triggers y=708; the line-selection for L=708 gives y_out=708; lines 707 and 808 give y_out=1023.
- Spawn, then re-request immediately -> spawn_ready_out=0 until y <= 620, i.e. after 25 frames; then the second spawn goes to slot1, y=720.
- Fill 4 slots at spacing -> active_count_out=4, spawn_ready_out=0; the oldest arrow reaches y=0 after 180 frames and then shows miss_out pulse with count 3.
- hit_in with oldest y=116 -> hit_ok_out pulse, slot cleared; hit_in with oldest y=200 -> hit_bad_out, slot kept; hit_in during UPDATE -> serviced 1 cycle after UPDATE ends.
- Assert rst_in during UPDATE at idx=2 -> all outputs at reset values immediately; slots empty afterwards.
